fifo_protocol_monitor: RTL

- Synthesizable, parametrised protocol monitor for any FIFO in the design.
- Snoops the FIFO's read/write strobes, status flags, occupancy count and (optionally) pointers, then checks them cycle-by-cycle against an internal reference model.
- Records violations in sticky flags, a first-error capture register and a saturating error counter.
- Instantiated alongside each FIFO under test; outputs are observed by the testbench scoreboard or mapped to debug registers in silicon.

---
 rtl/fifo_protocol_monitor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fifo_protocol_monitor.sv
// Purpose: passive protocol checker that shadows a FIFO's occupancy/pointers and records violations.
// Latency: a violation sampled at edge N is on err_flags/first_err_*/err_count after edge N; err_any is combinational.
// Backpressure: none; pure observer, never stalls the FIFO. Optional macro FIFO_MON_PTR_CHECK_EN adds pointer checks 6/7.
module fifo_protocol_monitor #(
    parameter  int DEPTH     = 16,
    parameter  int ERR_CNT_W = 8,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 err_clear,
    input  logic                 write,
    input  logic                 read,
    input  logic                 full,
    input  logic                 empty,
    input  logic [CNT_W-1:0]     cnt,
    input  logic [PTR_W-1:0]     wptr,
    input  logic [PTR_W-1:0]     rptr,
    output logic [CNT_W-1:0]     model_cnt,
    output logic [7:0]           err_flags,
    output logic                 err_any,
    output logic                 first_err_valid,
    output logic [2:0]           first_err_code,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0]     DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    logic                 wr_ok;
    logic                 rd_ok;
    logic                 hist_full_wr;
    logic                 hist_empty_rd;
    logic [CNT_W-1:0]     hist_cnt;
    logic [1:0]           ptr_fail;
    logic [7:0]           fail;
    logic                 fail_any;
    logic [2:0]           fail_code;
    logic [ERR_CNT_W-1:0] cnt_base;
    logic [ERR_CNT_W-1:0] cnt_next;

    // A write is refused at full and a read at empty, regardless of the other strobe.
    assign wr_ok = write && (model_cnt < DEPTH_C);
    assign rd_ok = read && (model_cnt != '0);

    // Reference occupancy follows the accepted strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            model_cnt <= '0;
        end else begin
            model_cnt <= model_cnt + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        end
    end

    // History of the previous sample for the full-write / empty-read disturb checks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_full_wr  <= 1'b0;
            hist_empty_rd <= 1'b0;
            hist_cnt      <= '0;
        end else begin
            hist_full_wr  <= full && write && !read;
            hist_empty_rd <= empty && read && !write;
            hist_cnt      <= cnt;
        end
    end

`ifdef FIFO_MON_PTR_CHECK_EN
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] model_wptr;
    logic [PTR_W-1:0] model_rptr;

    // Pointer models wrap at DEPTH-1, so non-power-of-two depths are handled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            model_wptr <= '0;
            model_rptr <= '0;
        end else begin
            if (wr_ok) begin
                model_wptr <= (model_wptr == PTR_LAST) ? '0 : model_wptr + PTR_W'(1);
            end
            if (rd_ok) begin
                model_rptr <= (model_rptr == PTR_LAST) ? '0 : model_rptr + PTR_W'(1);
            end
        end
    end

    assign ptr_fail = {rptr != model_rptr, wptr != model_wptr};
`else
    logic unused_ptrs;
    assign unused_ptrs = ^{wptr, rptr};
    assign ptr_fail    = 2'b00;
`endif

    // Per-check failure vector for the current sample; bit index is the error code.
    always_comb begin
        fail      = 8'h00;
        fail[0]   = cnt != model_cnt;
        fail[1]   = full != (model_cnt == DEPTH_C);
        fail[2]   = empty != (model_cnt == '0);
        fail[3]   = full && empty;
        fail[4]   = hist_full_wr && (!full || (cnt != hist_cnt));
        fail[5]   = hist_empty_rd && (!empty || (cnt != hist_cnt));
        fail[7:6] = ptr_fail;
    end

    assign fail_any = |fail;

    // Lowest failing index wins the first-error capture.
    always_comb begin
        fail_code = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (fail[i]) begin
                fail_code = 3'(i);
            end
        end
    end

    // Saturating count of failing cycles; a clear restarts from zero before this cycle's failure is added.
    always_comb begin
        cnt_base = err_clear ? '0 : err_count;
        cnt_next = cnt_base;
        if (fail_any && (cnt_base != CNT_MAX)) begin
            cnt_next = cnt_base + ERR_CNT_W'(1);
        end
    end

    // Error recording: sticky flags, first-error capture and counter; set wins over clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flags       <= 8'h00;
            first_err_valid <= 1'b0;
            first_err_code  <= 3'd0;
            err_count       <= '0;
        end else begin
            err_flags <= (err_clear ? 8'h00 : err_flags) | fail;
            if (fail_any && (err_clear || !first_err_valid)) begin
                first_err_valid <= 1'b1;
                first_err_code  <= fail_code;
            end else if (err_clear) begin
                first_err_valid <= 1'b0;
                first_err_code  <= 3'd0;
            end
            err_count <= cnt_next;
        end
    end

    assign err_any = |err_flags;

endmodule
